// File: rtl/regfile_dump_load.sv
// regfile_dump_load
//   Sequencer that bulk-dumps a range of register-file entries onto a valid/ready output
//   stream, or bulk-loads a range from a valid/ready input stream (debug context
//   save/restore). Drives the regfile write port (wen1/ad1/din1) and one combinational
//   read port (ad3/dout3).
// Ports
//   clk, rst                      clock (posedge) and asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; ready only while idle
//   cmd_load, cmd_base, cmd_len   1=load 0=dump, first address, register count minus 1
//   busy, done                    busy outside idle; done pulses for the single DONE cycle
//   rf_wen, rf_wa, rf_wd          regfile write port (registered single-cycle write pulse)
//   rf_ra, rf_rd                  regfile read address and combinational read data
//   out_valid/out_ready, out_data, out_last   dump stream
//   in_valid/in_ready, in_data                load stream
module regfile_dump_load #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_load,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [ADDR_WIDTH-1:0] cmd_len,
   output logic                  busy,
   output logic                  done,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_wa,
   output logic [DATA_WIDTH-1:0] rf_wd,
   output logic [ADDR_WIDTH-1:0] rf_ra,
   input  logic [DATA_WIDTH-1:0] rf_rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data
);

   typedef enum logic [1:0] {StIdle, StDump, StLoad, StDone} state_e;

   localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH-1:0]   remaining_q;
   logic                    rf_wen_q;
   logic [ADDR_WIDTH-1:0]   rf_wa_q;
   logic [DATA_WIDTH-1:0]   rf_wd_q;
   logic                    cmd_ready_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    out_valid_q;
   logic                    out_last_q;
   logic                    in_ready_q;

   logic                    out_xfer;
   logic                    in_xfer;
   logic [ADDR_WIDTH-1:0]   remaining_dec;
   logic [ADDR_WIDTH-1:0]   addr_inc;

   assign out_xfer      = out_valid_q & out_ready;
   assign in_xfer       = in_ready_q & in_valid;
   // Saturate at zero so a stray decrement can never wrap the count.
   assign remaining_dec = (remaining_q != '0) ? remaining_q - AddrOne : remaining_q;
   assign addr_inc      = addr_q + AddrOne;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         remaining_q <= '0;
         rf_wen_q    <= 1'b0;
         rf_wa_q     <= '0;
         rf_wd_q     <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         rf_wen_q <= 1'b0;
         done_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  addr_q      <= cmd_base;
                  remaining_q <= cmd_len;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (cmd_load) begin
                     state_q    <= StLoad;
                     in_ready_q <= 1'b1;
                  end else begin
                     state_q     <= StDump;
                     out_valid_q <= 1'b1;
                     out_last_q  <= (cmd_len == '0);
                  end
               end
            end
            StDump: begin
               // Address and flags only move on a transfer, so a stalled word stays stable.
               if (out_xfer) begin
                  addr_q      <= addr_inc;
                  remaining_q <= remaining_dec;
                  if (out_last_q) begin
                     state_q     <= StDone;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     out_last_q <= (remaining_q == AddrOne);
                  end
               end
            end
            StLoad: begin
               if (in_xfer) begin
                  rf_wen_q    <= 1'b1;
                  rf_wa_q     <= addr_q;
                  rf_wd_q     <= in_data;
                  addr_q      <= addr_inc;
                  remaining_q <= remaining_dec;
                  if (remaining_q == '0) begin
                     state_q    <= StDone;
                     in_ready_q <= 1'b0;
                     done_q     <= 1'b1;
                  end
               end
            end
            StDone: begin
               // The final load write pulse is on rf_wen during this cycle.
               state_q     <= StIdle;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rf_wen    = rf_wen_q;
   assign rf_wa     = rf_wa_q;
   assign rf_wd     = rf_wd_q;
   assign rf_ra     = addr_q;
   assign out_valid = out_valid_q;
   assign out_data  = rf_rd;
   assign out_last  = out_last_q;
   assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_regfile_dump_load.sv
// Directed bench for regfile_dump_load with a behavioural regfile that commits writes
// on the negedge. Inputs change and outputs are sampled just after negedges.
module tb_regfile_dump_load;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_load;
   logic [AW-1:0] cmd_base, cmd_len;
   logic          busy, done;
   logic          rf_wen;
   logic [AW-1:0] rf_wa, rf_ra;
   logic [DW-1:0] rf_wd, rf_rd;
   logic          out_valid, out_ready, out_last;
   logic [DW-1:0] out_data;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_data;

   int total_cnt = 0;
   int pass_cnt  = 0;

   // Regfile model; pre_mode 1: reg[i]=i*3, 2: reg[i]=0x1000+i.
   logic [DW-1:0] regs [32];
   logic [1:0]    pre_mode = 2'd0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pre_mode == 2'd1) begin
         for (int i = 0; i < 32; i++) regs[i] <= i * 3;
      end else if (pre_mode == 2'd2) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'h1000 + i;
      end else if (rf_wen) begin
         regs[rf_wa] <= rf_wd;
      end
   end

   assign rf_rd = regs[rf_ra];

   regfile_dump_load #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_base(cmd_base), .cmd_len(cmd_len),
      .busy(busy), .done(done),
      .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra(rf_ra), .rf_rd(rf_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
   );

   task automatic preload(input logic [1:0] m);
      pre_mode = m;
      @(negedge clk);
      #1 pre_mode = 2'd0;
   endtask

   // Offers one command (expects idle) and returns at the negedge after acceptance.
   task automatic send_cmd(input logic load, input logic [AW-1:0] base, input logic [AW-1:0] len);
      total_cnt++;
      if (cmd_ready !== 1'b1) $display("FAIL send_cmd cmd_ready: got %b want 1", cmd_ready);
      else pass_cnt++;
      cmd_valid = 1'b1; cmd_load = load; cmd_base = base; cmd_len = len;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({cmd_ready, busy, done, rf_wen, out_valid, out_last, in_ready} !== 7'b1000000)
         $display("FAIL reset flags: got %b want 1000000",
                  {cmd_ready, busy, done, rf_wen, out_valid, out_last, in_ready});
      else pass_cnt++;
      total_cnt++;
      if ({rf_wa, rf_wd, rf_ra} !== '0)
         $display("FAIL reset regs: wa=%0h wd=%0h ra=%0h want 0", rf_wa, rf_wd, rf_ra);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({cmd_ready, busy} !== 2'b10)
         $display("FAIL reset release: ready/busy=%b want 10", {cmd_ready, busy});
      else pass_cnt++;
   endtask

   task automatic test_dump_full();
      logic [DW-1:0] e;
      preload(2'd1);
      out_ready = 1'b1;
      send_cmd(1'b0, 5'd0, 5'd31);
      for (int i = 0; i < 32; i++) begin
         e = i * 3;
         total_cnt++;
         if ({out_valid, out_data, out_last, rf_ra} !== {1'b1, e, (i == 31), AW'(i)})
            $display("FAIL dump_full word %0d: v=%b d=%0h l=%b ra=%0d want 1 %0h %b %0d",
                     i, out_valid, out_data, out_last, rf_ra, e, (i == 31), i);
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if ({done, busy, out_valid} !== 3'b110)
         $display("FAIL dump_full done: done/busy/valid=%b want 110", {done, busy, out_valid});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({done, busy, cmd_ready} !== 3'b001)
         $display("FAIL dump_full idle: done/busy/ready=%b want 001", {done, busy, cmd_ready});
      else pass_cnt++;
   endtask

   task automatic test_load_wrap();
      logic [DW-1:0] d [4];
      logic [DW-1:0] e;
      logic [AW-1:0] a;
      d[0] = 32'hAAAA_0001; d[1] = 32'hBBBB_0002; d[2] = 32'hCCCC_0003; d[3] = 32'hDDDD_0004;
      preload(2'd2);
      send_cmd(1'b1, 5'd30, 5'd3);
      for (int k = 0; k < 4; k++) begin
         total_cnt++;
         if (in_ready !== 1'b1) $display("FAIL load_wrap in_ready %0d: got %b want 1", k, in_ready);
         else pass_cnt++;
         in_valid = 1'b1; in_data = d[k];
         @(negedge clk);
         a = 5'd30 + AW'(k);
         total_cnt++;
         if ({rf_wen, rf_wa, rf_wd} !== {1'b1, a, d[k]})
            $display("FAIL load_wrap write %0d: wen=%b wa=%0d wd=%0h want 1 %0d %0h",
                     k, rf_wen, rf_wa, rf_wd, a, d[k]);
         else pass_cnt++;
      end
      in_valid = 1'b0;
      total_cnt++;
      if ({done, in_ready} !== 2'b10)
         $display("FAIL load_wrap done: done/in_ready=%b want 10", {done, in_ready});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({rf_wen, cmd_ready} !== 2'b01)
         $display("FAIL load_wrap idle: wen/ready=%b want 01", {rf_wen, cmd_ready});
      else pass_cnt++;
      for (int i = 0; i < 32; i++) begin
         e = (i == 30) ? d[0] : (i == 31) ? d[1] : (i == 0) ? d[2] : (i == 1) ? d[3]
             : 32'h1000 + i;
         total_cnt++;
         if (regs[i] !== e) $display("FAIL load_wrap reg%0d: got %0h want %0h", i, regs[i], e);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] e;
      int idx = 0;
      int cyc = 0;
      out_ready = 1'b0;
      send_cmd(1'b0, 5'd4, 5'd2);
      while (idx < 3 && cyc < 30) begin
         out_ready = (cyc % 3 == 0);
         e = 32'h1004 + idx;
         total_cnt++;
         if ({out_valid, out_data, rf_ra, out_last} !== {1'b1, e, AW'(4 + idx), (idx == 2)})
            $display("FAIL backpressure cyc %0d: v=%b d=%0h ra=%0d l=%b want 1 %0h %0d %b",
                     cyc, out_valid, out_data, rf_ra, out_last, e, 4 + idx, (idx == 2));
         else pass_cnt++;
         if (out_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      total_cnt++;
      if ({idx == 3, done, out_valid} !== 3'b110)
         $display("FAIL backpressure end: words=%0d done=%b valid=%b want 3 1 0",
                  idx, done, out_valid);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n = 0;
      out_ready = 1'b0;
      send_cmd(1'b1, 5'd7, 5'd0);
      in_valid = 1'b1; in_data = 32'h0000_DEAD;
      @(negedge clk);
      in_valid = 1'b0;
      cmd_valid = 1'b1; cmd_load = 1'b0; cmd_base = 5'd7; cmd_len = 5'd0;
      while (!cmd_ready && n < 5) begin
         @(negedge clk);
         n++;
      end
      total_cnt++;
      if (cmd_ready !== 1'b1) $display("FAIL back_to_back wait: cmd_ready=%b want 1", cmd_ready);
      else pass_cnt++;
      @(negedge clk);
      cmd_valid = 1'b0;
      total_cnt++;
      if ({out_valid, out_data, out_last} !== {1'b1, 32'h0000_DEAD, 1'b1})
         $display("FAIL back_to_back data: v=%b d=%0h l=%b want 1 dead 1",
                  out_valid, out_data, out_last);
      else pass_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b1) $display("FAIL back_to_back done: got %b want 1", done);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_ignored_cmd();
      logic [DW-1:0] e;
      out_ready = 1'b1;
      send_cmd(1'b0, 5'd10, 5'd2);
      for (int k = 0; k < 3; k++) begin
         cmd_valid = 1'b1; cmd_load = 1'b1; cmd_base = 5'd0; cmd_len = 5'd31;
         e = 32'h100A + k;
         total_cnt++;
         if ({cmd_ready, out_valid, out_data, rf_ra} !== {1'b0, 1'b1, e, AW'(10 + k)})
            $display("FAIL ignored_cmd %0d: rdy=%b v=%b d=%0h ra=%0d want 0 1 %0h %0d",
                     k, cmd_ready, out_valid, out_data, rf_ra, e, 10 + k);
         else pass_cnt++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      total_cnt++;
      if ({done, rf_wen, in_ready} !== 3'b100)
         $display("FAIL ignored_cmd done: done/wen/in_ready=%b want 100", {done, rf_wen, in_ready});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({cmd_ready, busy, regs[0]} !== {1'b1, 1'b0, 32'hCCCC_0003})
         $display("FAIL ignored_cmd idle: rdy=%b busy=%b reg0=%0h want 1 0 cccc0003",
                  cmd_ready, busy, regs[0]);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_load();
      send_cmd(1'b1, 5'd20, 5'd3);
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_data = 32'hE000_0000 + k;
         @(negedge clk);
      end
      in_valid = 1'b0;
      total_cnt++;
      if (rf_wen !== 1'b1) $display("FAIL reset_mid pre wen: got %b want 1", rf_wen);
      else pass_cnt++;
      #1 rst = 1'b1;
      #1;
      total_cnt++;
      if ({rf_wen, cmd_ready, busy, in_ready, done} !== 5'b01000)
         $display("FAIL reset_mid async: wen/rdy/busy/inrdy/done=%b want 01000",
                  {rf_wen, cmd_ready, busy, in_ready, done});
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({regs[20], regs[21], regs[22], regs[23]} !==
          {32'hE000_0000, 32'hE000_0001, 32'h0000_1016, 32'h0000_1017})
         $display("FAIL reset_mid regs: %0h %0h %0h %0h want e0000000 e0000001 1016 1017",
                  regs[20], regs[21], regs[22], regs[23]);
      else pass_cnt++;
      total_cnt++;
      if ({cmd_ready, busy, in_ready} !== 3'b100)
         $display("FAIL reset_mid idle: rdy/busy/inrdy=%b want 100", {cmd_ready, busy, in_ready});
      else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_load = 1'b0; cmd_base = '0; cmd_len = '0;
      out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
      test_reset();
      test_dump_full();
      test_load_wrap();
      test_backpressure();
      test_back_to_back();
      test_ignored_cmd();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
